// File: rtl/pro12_buttons_control_leds_btn_debounce_pkg.sv
// Shared definitions for the button conditioning stage.
//   DefaultDebounceCycles : stable-cycle count for 10 ms at 50 MHz
//   cnt_width()           : width of a per-bit counter that can hold 0..n
//   idle_level()          : raw level of a released button for a given polarity
package pro12_buttons_control_leds_btn_debounce_pkg;

    localparam int unsigned DefaultDebounceCycles = 500000;

    // Never returns 0 so a counter declaration stays legal even for a
    // degenerate n; the top rejects n == 0 separately.
    function automatic int unsigned cnt_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic idle_level(input logic active_low);
        return active_low;
    endfunction

endpackage

// File: rtl/pro12_buttons_control_leds_btn_debounce_bit.sv
// One debounce channel: 2-flop synchroniser, stability counter, stable flop
// and registered press/release pulses.
//   clk, reset_n   : clock, asynchronous active-low reset
//   raw            : asynchronous pad input
//   level          : debounced level, raw polarity
//   held           : debounced level, active-high
//   press_pulse    : 1-cycle pulse when held goes 0 -> 1
//   release_pulse  : 1-cycle pulse when held goes 1 -> 0
module pro12_buttons_control_leds_btn_debounce_bit
    import pro12_buttons_control_leds_btn_debounce_pkg::*;
#(
    parameter logic        idle = 1'b1,
    parameter int unsigned N    = DefaultDebounceCycles
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic held,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int unsigned      CntW    = cnt_width(N);
    localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

    logic            sync1_q;
    logic            sync2_q;
    logic            stable_q;
    logic            press_q;
    logic            release_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= idle;
            sync2_q   <= idle;
            stable_q  <= idle;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= raw;
            sync2_q   <= sync1_q;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CntLast) begin
                // Pulses are registered alongside stable so they coincide
                // with the first cycle the new level is visible.
                stable_q  <= sync2_q;
                cnt_q     <= '0;
                press_q   <= (sync2_q != idle);
                release_q <= (sync2_q == idle);
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end
    end

    assign level         = stable_q;
    assign held          = stable_q ^ idle;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

endmodule

// File: rtl/pro12_buttons_control_leds_btn_debounce.sv
// Button conditioning stage: synchronises and debounces each KEY bit
// independently and emits press/release pulses.
//   clk, reset_n   : clock, asynchronous active-low reset
//   btn_raw        : raw pad inputs (asynchronous)
//   db_out         : debounced level, raw polarity (to PIO in_port)
//   pressed        : debounced level, active-high
//   press_pulse    : 1-cycle pulse per bit on debounced press
//   release_pulse  : 1-cycle pulse per bit on debounced release
module pro12_buttons_control_leds_btn_debounce
    import pro12_buttons_control_leds_btn_debounce_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] pressed,
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pro12_buttons_control_leds_btn_debounce_bit #(
            .idle (idle_level(ACTIVE_LOW)),
            .N    (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk           (clk),
            .reset_n       (reset_n),
            .raw           (btn_raw[i]),
            .level         (db_out[i]),
            .held          (pressed[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_pro12_buttons_control_leds_btn_debounce.sv
module tb_pro12_buttons_control_leds_btn_debounce;

    localparam int unsigned N    = 8;
    localparam logic [3:0]  IDLE = 4'b1111;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] btn_raw = 4'b1111;
    logic [3:0] db_out, pressed, press_pulse, release_pulse;

    int checks = 0;
    int errors = 0;

    // Reference model: a bit's debounced level adopts a value once the
    // 2-cycle-delayed raw input has shown that value for N consecutive edges.
    logic [3:0] m_p1, m_p2, m_stable, m_run_val, m_press, m_release;
    int         m_run_len [4];

    pro12_buttons_control_leds_btn_debounce #(
        .WIDTH           (4),
        .DEBOUNCE_CYCLES (N),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_raw       (btn_raw),
        .db_out        (db_out),
        .pressed       (pressed),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_p1      = IDLE;
        m_p2      = IDLE;
        m_stable  = IDLE;
        m_run_val = IDLE;
        m_press   = '0;
        m_release = '0;
        for (int i = 0; i < 4; i++) m_run_len[i] = 0;
    endtask

    // Advance one clock edge, update the model and compare all outputs.
    task automatic step();
        if (!reset_n) begin
            model_reset();
        end else begin
            m_press   = '0;
            m_release = '0;
            for (int i = 0; i < 4; i++) begin
                if (m_p2[i] == m_run_val[i]) begin
                    if (m_run_len[i] < N + 1) m_run_len[i]++;
                end else begin
                    m_run_val[i] = m_p2[i];
                    m_run_len[i] = 1;
                end
                if (m_run_len[i] >= N && m_run_val[i] != m_stable[i]) begin
                    m_stable[i] = m_run_val[i];
                    if (m_stable[i] != IDLE[i]) m_press[i] = 1'b1;
                    else                        m_release[i] = 1'b1;
                end
            end
            m_p2 = m_p1;
            m_p1 = btn_raw;
        end
        @(posedge clk);
        #1;
        checks++;
        if (db_out !== m_stable || pressed !== (m_stable ^ IDLE) ||
            press_pulse !== m_press || release_pulse !== m_release) begin
            errors++;
            $display("FAIL model t=%0t: got db=%b pr=%b pp=%b rp=%b, want db=%b pr=%b pp=%b rp=%b",
                     $time, db_out, pressed, press_pulse, release_pulse,
                     m_stable, m_stable ^ IDLE, m_press, m_release);
        end
    endtask

    task automatic settle(input logic [3:0] val);
        btn_raw = val;
        for (int k = 0; k < 14; k++) step();
    endtask

    task automatic test_reset();
        int hit;
        hit = -1;
        reset_n = 1'b0;
        btn_raw = 4'b0000;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) step();
        checks++;
        if (db_out !== 4'b1111 || pressed !== 4'b0000 || press_pulse !== 4'b0000 ||
            release_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: got db=%b pr=%b pp=%b rp=%b, want 1111 0000 0000 0000",
                     db_out, pressed, press_pulse, release_pulse);
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (press_pulse == 4'b1111 && hit < 0) hit = k;
        end
        checks++;
        if (hit != 10 || pressed !== 4'b1111) begin
            errors++;
            $display("FAIL held_through_reset: got pulse cycle %0d pressed=%b, want 10 1111",
                     hit, pressed);
        end
    endtask

    task automatic test_clean_press();
        int hit_p, hit_r, width;
        settle(4'b1111);
        hit_p = -1; hit_r = -1; width = 0;
        btn_raw[0] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (press_pulse[0]) width++;
            if (db_out[0] == 1'b0 && hit_p < 0) begin
                hit_p = k;
                checks++;
                if (press_pulse[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL press_align: got press_pulse[0]=%b, want 1", press_pulse[0]);
                end
            end
        end
        checks++;
        if (hit_p != 10 || width != 1) begin
            errors++;
            $display("FAIL clean_press: got cycle %0d width %0d, want 10 1", hit_p, width);
        end
        btn_raw[0] = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (release_pulse[0] && hit_r < 0) hit_r = k;
        end
        checks++;
        if (hit_r != 10) begin
            errors++;
            $display("FAIL clean_release: got cycle %0d, want 10", hit_r);
        end
    endtask

    task automatic test_glitch();
        int pulses;
        pulses = 0;
        settle(4'b1111);
        btn_raw[1] = 1'b0;
        for (int k = 0; k < N - 1; k++) step();
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 14; k++) begin
            step();
            if (press_pulse != 0 || release_pulse != 0) pulses++;
        end
        checks++;
        if (pulses != 0 || db_out !== 4'b1111) begin
            errors++;
            $display("FAIL glitch_reject: got %0d pulses db=%b, want 0 1111", pulses, db_out);
        end
        btn_raw[1] = 1'b0;
        for (int k = 0; k < N; k++) step();
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            if (press_pulse[1]) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL glitch_accept: got %0d press pulses, want 1", pulses);
        end
        for (int k = 0; k < 14; k++) step();
    endtask

    task automatic test_bounce();
        int pulses, hit;
        pulses = 0; hit = -1;
        settle(4'b1111);
        for (int k = 0; k < 40; k++) begin
            if (k % 3 == 0) btn_raw[2] = ~btn_raw[2];
            step();
            if (press_pulse[2]) pulses++;
        end
        btn_raw[2] = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (press_pulse[2]) begin
                pulses++;
                if (hit < 0) hit = k;
            end
        end
        checks++;
        if (pulses != 1 || hit != 10) begin
            errors++;
            $display("FAIL bounce: got %0d pulses at cycle %0d, want 1 at 10", pulses, hit);
        end
    endtask

    task automatic test_simultaneous();
        int bad;
        bad = 0;
        settle(4'b1111);
        btn_raw = 4'b0101;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 10) begin
                if (press_pulse !== 4'b1010) bad++;
            end else if (press_pulse !== 4'b0000) begin
                bad++;
            end
            if (release_pulse !== 4'b0000) bad++;
        end
        checks++;
        if (bad != 0 || pressed !== 4'b1010) begin
            errors++;
            $display("FAIL simultaneous: got %0d bad cycles pressed=%b, want 0 1010", bad, pressed);
        end
    endtask

    task automatic test_reset_mid_count();
        int hit;
        hit = -1;
        settle(4'b1110);
        btn_raw[3] = 1'b0;
        for (int k = 0; k < 5; k++) step();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (db_out !== 4'b1111 || pressed !== 4'b0000 || press_pulse !== 4'b0000 ||
            release_pulse !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset: got db=%b pr=%b pp=%b rp=%b, want 1111 0000 0000 0000",
                     db_out, pressed, press_pulse, release_pulse);
        end
        step();
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (press_pulse != 0 && hit < 0) begin
                hit = k;
                checks++;
                if (press_pulse !== 4'b1001) begin
                    errors++;
                    $display("FAIL restart_bits: got %b, want 1001", press_pulse);
                end
            end
        end
        checks++;
        if (hit != 10) begin
            errors++;
            $display("FAIL restart_count: got cycle %0d, want 10", hit);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 5) == 0) btn_raw[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 29) == 0) btn_raw = 4'($urandom);
            if (k % 400 == 399) reset_n = 1'b0;
            else                reset_n = 1'b1;
            step();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
